// File: rtl/sponge_block_padder.sv
// sponge_block_padder
// Collects 64-bit message lanes, applies the SHA-3/SHAKE domain suffix and
// pad10*1, and emits full 1344-bit rate blocks laid out for the absorb
// stage (lane i at bits [64i+63:64i], zero above the rate).
// Optional feature: define KECCAK_BLK_CNT_EN to add the blk_idx output
// (zero-based block index within the message, saturating at 0xFFFF).
`timescale 1ns/1ps
module sponge_block_padder #(
  parameter int LANE_W   = 64,
  parameter int MAX_RATE = 1344
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          c_mode,
  output logic                mode_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANE_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [3:0]          in_bytes,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [MAX_RATE-1:0] blk_data,
  output logic                blk_last
`ifdef KECCAK_BLK_CNT_EN
  ,
  output logic [15:0]         blk_idx
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAD  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                state_r;
  logic [4:0]            cnt_r;
  logic [4:0]            rate_m1_r;
  logic [7:0]            suffix_r;
  logic                  pend_r;
  logic [MAX_RATE-1:0]   blk_r;
  logic                  blk_valid_r;
  logic                  blk_last_r;
  logic                  in_ready_r;
  logic                  mode_err_r;
`ifdef KECCAK_BLK_CNT_EN
  logic [15:0]           idx_r;
`endif

  logic [3:0]            b_eff_s;
  logic                  at_end_s;
  logic [10:0]           lane_base_s;
  logic [10:0]           next_base_s;
  logic [10:0]           term_pos_s;
  logic [MAX_RATE-1:0]   fill_blk_s;
  logic [MAX_RATE-1:0]   pad_blk_s;

  // Rate in lanes for each mode; invalid modes never reach the latch.
  function automatic logic [4:0] rate_of(input logic [2:0] m);
    case (m)
      3'd0:    rate_of = 5'd18;
      3'd1:    rate_of = 5'd17;
      3'd2:    rate_of = 5'd13;
      3'd3:    rate_of = 5'd9;
      3'd4:    rate_of = 5'd21;
      3'd5:    rate_of = 5'd17;
      default: rate_of = 5'd0;
    endcase
  endfunction

  // Domain separation suffix: SHA3 uses 01||1, SHAKE uses 1111||1.
  function automatic logic [7:0] suffix_of(input logic [2:0] m);
    case (m)
      3'd4, 3'd5: suffix_of = 8'h1F;
      default:    suffix_of = 8'h06;
    endcase
  endfunction

  // Keep bytes below b, put the suffix in byte b, zero the rest.
  function automatic logic [63:0] pad_lane(input logic [63:0] d,
                                           input logic [3:0]  b,
                                           input logic [7:0]  sfx);
    pad_lane = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < b) begin
        pad_lane[8*k +: 8] = d[8*k +: 8];
      end else if (4'(k) == b) begin
        pad_lane[8*k +: 8] = sfx;
      end else begin
        pad_lane[8*k +: 8] = 8'h00;
      end
    end
  endfunction

  // Next block contents for an accepted lane, and the pad-only block.
  always_comb begin
    b_eff_s     = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    at_end_s    = (cnt_r == rate_m1_r);
    lane_base_s = {1'b0, cnt_r, 5'd0} << 1;
    next_base_s = {1'b0, cnt_r + 5'd1, 5'd0} << 1;
    term_pos_s  = {rate_m1_r, 6'd63};
    fill_blk_s  = blk_r;
    if (in_last) begin
      if (b_eff_s == 4'd8) begin
        fill_blk_s[lane_base_s +: 64] = in_data;
        if (!at_end_s) begin
          fill_blk_s[next_base_s +: 8] = suffix_r;
          fill_blk_s[term_pos_s]       = 1'b1;
        end else begin
          fill_blk_s[term_pos_s] = fill_blk_s[term_pos_s];
        end
      end else begin
        fill_blk_s[lane_base_s +: 64] = pad_lane(in_data, b_eff_s, suffix_r);
        fill_blk_s[term_pos_s]        = 1'b1;
      end
    end else begin
      fill_blk_s[lane_base_s +: 64] = in_data;
    end
    pad_blk_s             = '0;
    pad_blk_s[7:0]        = suffix_r;
    pad_blk_s[term_pos_s] = 1'b1;
  end

  // Padder FSM: lane collection, padding and block handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      rate_m1_r   <= 5'd0;
      suffix_r    <= 8'h00;
      pend_r      <= 1'b0;
      blk_r       <= '0;
      blk_valid_r <= 1'b0;
      blk_last_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      mode_err_r  <= 1'b0;
`ifdef KECCAK_BLK_CNT_EN
      idx_r       <= 16'd0;
`endif
    end else begin
      mode_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (c_mode <= 3'd5) begin
              rate_m1_r  <= rate_of(c_mode) - 5'd1;
              suffix_r   <= suffix_of(c_mode);
              blk_r      <= '0;
              cnt_r      <= 5'd0;
              pend_r     <= 1'b0;
              blk_last_r <= 1'b0;
              in_ready_r <= 1'b1;
              state_r    <= ST_FILL;
`ifdef KECCAK_BLK_CNT_EN
              idx_r      <= 16'd0;
`endif
            end else begin
              mode_err_r <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (in_valid && in_ready_r) begin
            blk_r <= fill_blk_s;
            if (in_last) begin
              in_ready_r  <= 1'b0;
              blk_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
              if ((b_eff_s == 4'd8) && at_end_s) begin
                blk_last_r <= 1'b0;
                pend_r     <= 1'b1;
              end else begin
                blk_last_r <= 1'b1;
              end
            end else if (at_end_s) begin
              in_ready_r  <= 1'b0;
              blk_valid_r <= 1'b1;
              blk_last_r  <= 1'b0;
              state_r     <= ST_HOLD;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end
        end
        ST_HOLD: begin
          if (blk_ready) begin
            blk_valid_r <= 1'b0;
`ifdef KECCAK_BLK_CNT_EN
            if (idx_r != 16'hFFFF) begin
              idx_r <= idx_r + 16'd1;
            end
`endif
            if (blk_last_r) begin
              blk_last_r <= 1'b0;
              state_r    <= ST_IDLE;
            end else if (pend_r) begin
              pend_r  <= 1'b0;
              state_r <= ST_PAD;
            end else begin
              blk_r      <= '0;
              cnt_r      <= 5'd0;
              in_ready_r <= 1'b1;
              state_r    <= ST_FILL;
            end
          end
        end
        ST_PAD: begin
          blk_r       <= pad_blk_s;
          blk_last_r  <= 1'b1;
          blk_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          blk_valid_r <= 1'b0;
          blk_last_r  <= 1'b0;
          pend_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mode_err  = mode_err_r;
  assign in_ready  = in_ready_r;
  assign blk_valid = blk_valid_r;
  assign blk_data  = blk_r;
  assign blk_last  = blk_last_r;
`ifdef KECCAK_BLK_CNT_EN
  assign blk_idx   = idx_r;
`endif

endmodule

// File: tb/tb_sponge_block_padder.sv
// Scoreboard bench for sponge_block_padder: expected blocks are queued as
// stimulus is issued; a monitor pops and compares on each block handshake.
`timescale 1ns/1ps
module tb_sponge_block_padder;
  localparam int RW = 1344;
  localparam logic [63:0] TERM = 64'h8000000000000000;

  typedef struct packed {
    logic          last;
    logic [RW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int mode_err_cnt = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    c_mode = 3'd0;
  logic          mode_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = 64'd0;
  logic          in_last = 1'b0;
  logic [3:0]    in_bytes = 4'd0;
  logic          blk_valid;
  logic          blk_ready = 1'b1;
  logic [RW-1:0] blk_data;
  logic          blk_last;
`ifdef KECCAK_BLK_CNT_EN
  logic [15:0]   blk_idx;
`endif

  sponge_block_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .c_mode    (c_mode),
    .mode_err  (mode_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
`ifdef KECCAK_BLK_CNT_EN
    ,
    .blk_idx   (blk_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [RW-1:0] put(input logic [RW-1:0] v, input int i, input logic [63:0] d);
    put = v;
    put[i*64 +: 64] = d;
  endfunction

  function automatic logic [63:0] pat(input int i);
    pat = {32'hA5000000 + 32'(i), 32'h00C0FFEE};
  endfunction

  // Monitor: counts mode_err pulses and checks every delivered block.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mode_err === 1'b1) mode_err_cnt++;
    if (rst_n === 1'b1 && blk_valid === 1'b1 && blk_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_block: got a block, want none");
      end else begin
        e = sb.pop_front();
        check("blk_data", blk_data, e.data);
        check("blk_last", RW'(blk_last), RW'(e.last));
      end
    end
  end

  task automatic do_start(input logic [2:0] m);
    @(posedge clk); #1;
    start = 1'b1;
    c_mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    c_mode = 3'd0;
  endtask

  task automatic send_lane(input logic [63:0] d, input logic l, input logic [3:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    in_bytes = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL lane_accept: got in_ready=%b, want 1 within 100 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d blocks pending, want 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Directed stimulus with hand-computed expected blocks.
  initial begin
    exp_t e;
    logic [RW-1:0] v;
    int me0;
    int n;

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    check("rst_in_ready", RW'(in_ready), RW'(1'b0));
    check("rst_blk_valid", RW'(blk_valid), RW'(1'b0));
    check("rst_blk_last", RW'(blk_last), RW'(1'b0));
    check("rst_mode_err", RW'(mode_err), RW'(1'b0));
    check("rst_blk_data", blk_data, '0);
    @(negedge clk) rst_n = 1'b1;

    // Empty SHA3-256 message
    v = '0;
    v = put(v, 0, 64'h06);
    v = put(v, 16, TERM);
    e.last = 1'b1; e.data = v; sb.push_back(e);
    do_start(3'd1);
    send_lane(64'h0, 1'b1, 4'd0);
    wait_drain();

    // SHA3-512 single partial lane
    v = '0;
    v = put(v, 0, 64'h0000000006667788);
    v = put(v, 8, TERM);
    e.last = 1'b1; e.data = v; sb.push_back(e);
    do_start(3'd3);
    send_lane(64'h1122334455667788, 1'b1, 4'd3);
    wait_drain();

    // SHAKE128 exactly one full rate: data block, then pad-only block
    me0 = mode_err_cnt;
    v = '0;
    for (int i = 0; i < 21; i++) v = put(v, i, pat(i));
    e.last = 1'b0; e.data = v; sb.push_back(e);
    v = '0;
    v = put(v, 0, 64'h1F);
    v = put(v, 20, TERM);
    e.last = 1'b1; e.data = v; sb.push_back(e);
    do_start(3'd4);
    for (int i = 0; i < 21; i++) send_lane(pat(i), (i == 20), 4'd8);
    wait_drain();
    check("shake128_no_mode_err", RW'(mode_err_cnt - me0), RW'(0));

    // SHA3-384 suffix and terminator share the last byte
    v = '0;
    for (int i = 0; i < 12; i++) v = put(v, i, pat(i));
    v = put(v, 12, 64'h86FFFFFFFFFFFFFF);
    e.last = 1'b1; e.data = v; sb.push_back(e);
    do_start(3'd2);
    for (int i = 0; i < 12; i++) send_lane(pat(i), 1'b0, 4'd8);
    send_lane(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd7);
    wait_drain();

    // SHAKE256 partial lane of 7 bytes
    v = '0;
    v = put(v, 0, 64'h1F23456789ABCDEF);
    v = put(v, 16, TERM);
    e.last = 1'b1; e.data = v; sb.push_back(e);
    do_start(3'd5);
    send_lane(64'h0123456789ABCDEF, 1'b1, 4'd7);
    wait_drain();

    // Backpressure: block held stable, then async reset mid-hold
    blk_ready = 1'b0;
    v = '0;
    v = put(v, 0, 64'h06);
    v = put(v, 16, TERM);
    do_start(3'd1);
    send_lane(64'h0, 1'b1, 4'd0);
    n = 0;
    while (blk_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", RW'(blk_valid), RW'(1'b1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", RW'(blk_valid), RW'(1'b1));
      check("hold_in_ready", RW'(in_ready), RW'(1'b0));
      check("hold_data", blk_data, v);
      check("hold_last", RW'(blk_last), RW'(1'b1));
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", RW'(blk_valid), RW'(1'b0));
    check("async_rst_last", RW'(blk_last), RW'(1'b0));
    check("async_rst_in_ready", RW'(in_ready), RW'(1'b0));
    check("async_rst_mode_err", RW'(mode_err), RW'(1'b0));
    check("async_rst_data", blk_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    blk_ready = 1'b1;

    // Invalid mode: one mode_err pulse, remains idle
    me0 = mode_err_cnt;
    do_start(3'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bad_mode_pulses", RW'(mode_err_cnt - me0), RW'(1));
    check("bad_mode_in_ready", RW'(in_ready), RW'(1'b0));
    check("bad_mode_blk_valid", RW'(blk_valid), RW'(1'b0));

    // SHA3-224 full last lane with in_bytes above 8 (treated as 8)
    v = '0;
    v = put(v, 0, 64'hDEADBEEFCAFEF00D);
    v = put(v, 1, 64'h06);
    v = put(v, 17, TERM);
    e.last = 1'b1; e.data = v; sb.push_back(e);
    do_start(3'd0);
    send_lane(64'hDEADBEEFCAFEF00D, 1'b1, 4'd12);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
